// File: rtl/pit_pkg.sv
// Shared types for the PIT dispatcher: event layout, op encodings and FSM states.
package pit_pkg;

    localparam int ENTRY_W = 11;
    localparam int BLOCK_W = 10;
    localparam int META_W  = 8;
    localparam int SRC_W   = 2;
    localparam int LEN_W   = 6;
    localparam int EVT_W   = ENTRY_W + META_W + 1;
    localparam int ADDR_W  = BLOCK_W + LEN_W;

    localparam logic [SRC_W-1:0] SRC_USER = 2'b01;

    typedef enum logic [1:0] {
        OP_FWD   = 2'd1,
        OP_WRITE = 2'd2,
        OP_READ  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FWD   = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } state_e;

    // Field order matches the enqueue concatenation {table_entry, meta_data, interest_packet}.
    typedef struct packed {
        logic               present;
        logic [BLOCK_W-1:0] block;
        logic [SRC_W-1:0]   src;
        logic [LEN_W-1:0]   len;
        logic               interest;
    } evt_t;

    function automatic op_e classify(evt_t e);
        if (e.src != SRC_USER)
            return OP_WRITE;
        else if (e.present)
            return OP_READ;
        else
            return OP_FWD;
    endfunction

endpackage

// File: rtl/pit_evt_fifo.sv
// Synchronous event queue with a registered head word and full/empty flags.
module pit_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_n;
    logic [AW:0]      count;
    logic             wr_ok;
    logic             rd_ok;
    logic             empty_after_pop;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // A write while full is refused even if the head is popped in the same cycle.
    assign wr_ok           = wr_en && !full;
    assign rd_ok           = rd_en && !empty;
    assign rd_ptr_n        = rd_ptr + AW'(rd_ok);
    assign empty_after_pop = empty || (count == ONE_C && rd_ok);

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_data;
    end

    // rd_data always holds the word at the head of the queue for the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_ptr_n;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
            if (wr_ok && empty_after_pop)
                rd_data <= wr_data;
            else
                rd_data <= mem[rd_ptr_n];
        end
    end

endmodule

// File: rtl/pit_dispatch.sv
// PIT event dispatcher: queues lookup results and drives FIB forwards or payload bursts.
// Optional statistics counters are built when PIT_DISPATCH_STATS_EN is defined.
//
// state    | meaning
// ST_IDLE  | wait for a queued event; pop and classify it on exit
// ST_FWD   | hold interest forward toward the FIB until fib_ready
// ST_WRITE | store payload beats (mem_we=1), then READ if an interest is pending
// ST_READ  | read payload beats toward SPI, spi_sof on beat 0
module pit_dispatch
    import pit_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pit_in_bit,
    input  logic [10:0] table_entry,
    input  logic [7:0]  meta_data,
    input  logic        interest_packet,
    input  logic        rejected,
    output logic        fib_valid,
    input  logic        fib_ready,
    output logic [9:0]  fib_addr,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic        spi_sof,
    output logic        q_full,
    output logic        drop,
    output logic [15:0] reject_cnt,
    output logic [15:0] drop_cnt
);

    localparam logic [LEN_W-1:0] BEAT_ONE = LEN_W'(1);

    state_e           state_q, state_d;
    evt_t             cur_q, cur_d;
    evt_t             in_evt;
    evt_t             head;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic             pop;
    logic             empty;
    logic             drop_evt;
    logic             last_beat;
    logic             no_beats;

    assign in_evt   = {table_entry, meta_data, interest_packet};
    assign drop_evt = pit_in_bit && q_full;

    pit_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (pit_in_bit),
        .wr_data (in_evt),
        .rd_en   (pop),
        .rd_data (head),
        .full    (q_full),
        .empty   (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            beat_q  <= '0;
            drop    <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            beat_q  <= beat_d;
            drop    <= drop_evt;
        end
    end

    assign no_beats  = (cur_q.len == '0);
    assign last_beat = (beat_q == cur_q.len - BEAT_ONE);

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        beat_d    = beat_q;
        pop       = 1'b0;
        fib_valid = 1'b0;
        fib_addr  = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        spi_sof   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop    = 1'b1;
                    cur_d  = head;
                    beat_d = '0;
                    case (classify(head))
                        OP_FWD:  state_d = ST_FWD;
                        OP_READ: state_d = ST_READ;
                        default: state_d = ST_WRITE;
                    endcase
                end
            end

            ST_FWD: begin
                fib_valid = 1'b1;
                fib_addr  = cur_q.block;
                if (fib_ready)
                    state_d = ST_IDLE;
            end

            ST_WRITE: begin
                if (!no_beats) begin
                    mem_en   = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = {cur_q.block, beat_q};
                end
                if (no_beats || last_beat) begin
                    beat_d  = '0;
                    state_d = cur_q.interest ? ST_READ : ST_IDLE;
                end else begin
                    beat_d = beat_q + BEAT_ONE;
                end
            end

            ST_READ: begin
                if (!no_beats) begin
                    mem_en   = 1'b1;
                    mem_addr = {cur_q.block, beat_q};
                    spi_sof  = (beat_q == '0);
                end
                if (no_beats || last_beat) begin
                    beat_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    beat_d = beat_q + BEAT_ONE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

`ifdef PIT_DISPATCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reject_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            if (rejected && reject_cnt != 16'hFFFF)
                reject_cnt <= reject_cnt + 16'd1;
            if (drop_evt && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    logic unused_rejected;
    assign unused_rejected = rejected;
    assign reject_cnt      = '0;
    assign drop_cnt        = '0;
`endif

endmodule

// File: tb/tb_pit_dispatch.sv
// Directed bench for pit_dispatch with scoreboard queues for memory beats and FIB forwards.
module tb_pit_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        pit_in_bit;
    logic [10:0] table_entry;
    logic [7:0]  meta_data;
    logic        interest_packet;
    logic        rejected;
    logic        fib_valid;
    logic        fib_ready;
    logic [9:0]  fib_addr;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic        spi_sof;
    logic        q_full;
    logic        drop;
    logic [15:0] reject_cnt;
    logic [15:0] drop_cnt;

`ifdef PIT_DISPATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    logic [17:0] exp_mem [$];
    logic [9:0]  exp_fib [$];
    logic [17:0] mon_mem;
    logic [9:0]  mon_fib;
    logic        pend = 1'b0;
    logic [9:0]  pend_addr = '0;

    always #5 clk = ~clk;

    pit_dispatch #(.FIFO_DEPTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .pit_in_bit      (pit_in_bit),
        .table_entry     (table_entry),
        .meta_data       (meta_data),
        .interest_packet (interest_packet),
        .rejected        (rejected),
        .fib_valid       (fib_valid),
        .fib_ready       (fib_ready),
        .fib_addr        (fib_addr),
        .mem_en          (mem_en),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .spi_sof         (spi_sof),
        .q_full          (q_full),
        .drop            (drop),
        .reject_cnt      (reject_cnt),
        .drop_cnt        (drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_beat(input logic we, input logic sof, input logic [9:0] blk, input int beat);
        exp_mem.push_back({we, sof, blk, 6'(beat)});
    endtask

    // Reference behaviour of one accepted event.
    task automatic model(input logic [10:0] e, input logic [7:0] m, input logic ip);
        if (m[7:6] == 2'b01 && !e[10]) begin
            exp_fib.push_back(e[9:0]);
        end else begin
            if (m[7:6] != 2'b01)
                for (int i = 0; i < int'(m[5:0]); i++) exp_beat(1'b1, 1'b0, e[9:0], i);
            if (m[7:6] == 2'b01 || ip)
                for (int i = 0; i < int'(m[5:0]); i++) exp_beat(1'b0, i == 0, e[9:0], i);
        end
    endtask

    task automatic push(input logic [10:0] e, input logic [7:0] m, input logic ip, input bit kept);
        pit_in_bit      = 1'b1;
        table_entry     = e;
        meta_data       = m;
        interest_packet = ip;
        if (kept) model(e, m, ip);
        step();
        pit_in_bit      = 1'b0;
        interest_packet = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_mem.size() != 0 || exp_fib.size() != 0) && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_drain_left"}, 64'(exp_mem.size() + exp_fib.size()), 64'd0);
        repeat (3) step();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (mem_en) begin
                chk("mem_beat_expected", 64'(exp_mem.size() != 0), 64'd1);
                if (exp_mem.size() != 0) begin
                    mon_mem = exp_mem.pop_front();
                    chk("mem_beat", {mem_we, spi_sof, mem_addr}, mon_mem);
                end
            end
            if (pend)
                chk("fib_hold", {fib_valid, fib_addr}, {1'b1, pend_addr});
            if (fib_valid && fib_ready) begin
                chk("fib_expected", 64'(exp_fib.size() != 0), 64'd1);
                if (exp_fib.size() != 0) begin
                    mon_fib = exp_fib.pop_front();
                    chk("fib_addr", fib_addr, mon_fib);
                end
            end
            pend      = fib_valid && !fib_ready;
            pend_addr = fib_addr;
        end
    end

    initial begin
        rst             = 1'b1;
        pit_in_bit      = 1'b0;
        table_entry     = '0;
        meta_data       = '0;
        interest_packet = 1'b0;
        rejected        = 1'b0;
        fib_ready       = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        step();
        chk("reset_outputs",
            {fib_valid, fib_addr, mem_en, mem_we, mem_addr, spi_sof, q_full, drop, reject_cnt, drop_cnt},
            64'd0);

        // Forward held without ready, then overflow the queue behind it.
        push(11'h005, 8'h44, 1'b0, 1'b1);
        chk("fwd_latency_early", fib_valid, 1'b0);
        step();
        chk("fwd_valid", {fib_valid, fib_addr, mem_en}, {1'b1, 10'h005, 1'b0});
        repeat (3) step();
        for (int i = 0; i < 5; i++)
            push(11'h011 + 11'(i), 8'h44, 1'b0, i < 4);
        chk("ovf_full", q_full, 1'b1);
        chk("ovf_drop_pulse", drop, 1'b1);
        chk("ovf_drop_cnt", drop_cnt, STATS ? 16'd1 : 16'd0);
        step();
        chk("ovf_drop_single", drop, 1'b0);
        chk("ovf_still_full", q_full, 1'b1);
        fib_ready = 1'b1;
        drain("ovf");
        chk("ovf_empty_after", {q_full, fib_valid}, 2'b00);

        // Read burst of three beats.
        push(11'h403, 8'h43, 1'b0, 1'b1);
        drain("read3");

        // Write two beats then read them back for the pending interest.
        push(11'h40A, 8'h82, 1'b1, 1'b1);
        drain("write_read");

        // Zero-length read must occupy the FSM for one cycle only.
        fib_ready = 1'b0;
        push(11'h400, 8'h40, 1'b0, 1'b1);
        push(11'h0AB, 8'h44, 1'b0, 1'b1);
        chk("len0_c2", fib_valid, 1'b0);
        step();
        chk("len0_c3", fib_valid, 1'b0);
        step();
        chk("len0_fwd_next", {fib_valid, fib_addr}, {1'b1, 10'h0AB});
        fib_ready = 1'b1;
        drain("len0");

        // Rejected-data statistics.
        repeat (3) begin
            rejected = 1'b1;
            step();
            rejected = 1'b0;
            step();
        end
        chk("reject_cnt", reject_cnt, STATS ? 16'd3 : 16'd0);
        chk("drop_cnt_stable", drop_cnt, STATS ? 16'd1 : 16'd0);

        // Reset in the middle of an eight-beat write with another event queued.
        fib_ready = 1'b0;
        push(11'h00F, 8'h88, 1'b0, 1'b0);
        exp_beat(1'b1, 1'b0, 10'h00F, 0);
        exp_beat(1'b1, 1'b0, 10'h00F, 1);
        push(11'h077, 8'h44, 1'b0, 1'b0);
        step();
        step();
        chk("mid_write_beat2", {mem_en, mem_we, mem_addr}, {1'b1, 1'b1, 16'h03C2});
        rst = 1'b1;
        #1;
        chk("rst_outputs",
            {fib_valid, fib_addr, mem_en, mem_we, mem_addr, spi_sof, q_full, drop, reject_cnt, drop_cnt},
            64'd0);
        step();
        chk("rst_mem_en_next", mem_en, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_quiet", {fib_valid, mem_en, q_full}, 3'b000);
        end

        chk("scoreboard_mem_left", 64'(exp_mem.size()), 64'd0);
        chk("scoreboard_fib_left", 64'(exp_fib.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pit_dispatch.md
PIT_DISPATCH -- requirements
Module: pit_dispatch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the event queue depth (power of 2, 2..16).
REQ-002 SHALL have port clk  in  1  clock; reset rst, asynchronous, active-high.
REQ-003 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-004 SHALL have port pit_in_bit  in  1  one-cycle PIT lookup-valid strobe.
REQ-005 SHALL have port table_entry  in  11  PIT entry: [10] data-present, [9:0] block address.
REQ-006 SHALL have port meta_data  in  8  [7:6] source type (01 = user interest), [5:0] length in beats.
REQ-007 SHALL have port interest_packet  in  1  FIB data satisfies a pending interest.
REQ-008 SHALL have port rejected  in  1  one-cycle unsolicited-data strobe.
REQ-009 SHALL have port fib_valid / fib_ready / fib_addr  out/in/out  1/1/10  interest-forward handshake to FIB.
REQ-010 SHALL have port mem_en / mem_we / mem_addr  out/out/out  1/1/16  payload store beat port, addr = {block, beat[5:0]}.
REQ-011 SHALL have port spi_sof  out  1  pulse on first read beat toward SPI.
REQ-012 SHALL have port q_full / drop  out/out  1/1  queue full, one-cycle event-dropped pulse.
REQ-013 SHALL have port reject_cnt / drop_cnt  out/out  16/16  saturating statistics.

Function
REQ-014 SHALL enqueue {table_entry, meta_data, interest_packet} on every cycle pit_in_bit=1 and the queue is not full.
REQ-015 SHALL, with pit_in_bit=1 while full, discard the event and pulse drop next cycle; a same-cycle pop does not free space for it.
REQ-016 SHALL classify the head entry: type 01 with [10]=0 -> FWD; type 01 with [10]=1 -> READ; other type -> WRITE, then READ if interest_packet=1.
REQ-017 SHALL run FSM IDLE->{FWD,WRITE,READ}; head popped on IDLE exit; FWD->IDLE on fib_valid&fib_ready; WRITE->READ (interest_packet) or IDLE after last beat; READ->IDLE after last beat.
REQ-018 SHALL hold fib_valid and fib_addr stable in FWD until fib_ready; fib_valid low in all other states.
REQ-019 SHALL in WRITE/READ issue one beat per cycle, mem_en=1, mem_we=1 only in WRITE, beat counter 0..len-1, mem_addr={block,beat}.
REQ-020 SHALL treat len=0 as zero beats: WRITE/READ state lasts one cycle with mem_en=0, spi_sof=0.
REQ-021 SHALL pulse spi_sof coincident with beat 0 of every READ with len>0.
REQ-022 SHALL take minimum 1-cycle latency from enqueue to first beat/fib_valid (IDLE sees non-empty queue next cycle).
REQ-023 SHALL increment reject_cnt per rejected strobe and drop_cnt per dropped event, saturating at 16'hFFFF.
REQ-024 SHALL assert q_full combinationally from queue occupancy == FIFO_DEPTH.

Reset
REQ-025 SHALL on rst clear queue pointers, counters, beat counter, FSM to IDLE; all outputs 0.
REQ-026 SHALL abandon any in-progress burst or FWD handshake on rst with no further beats issued.

Configuration
REQ-027 SHALL, with PIT_DISPATCH_STATS_EN defined, implement reject_cnt and drop_cnt per REQ-023.
REQ-028 SHALL, without PIT_DISPATCH_STATS_EN, tie reject_cnt and drop_cnt to 0 with no counter flops; drop still pulses.

Structure
REQ-029 SHALL place op encodings (FWD/WRITE/READ), source-type code 2'b01, and entry field widths in shared package pit_pkg.
REQ-030 SHALL implement the queue as one sub-module pit_evt_fifo (sync, registered read, full/empty flags).

Verification
REQ-031 SHALL cover: pit_in_bit with entry 11'h005, meta 8'h44 -> fib_valid, fib_addr=10'h005 held until fib_ready, 0 mem beats.
REQ-032 SHALL cover: entry 11'h403, meta 8'h43 -> 3 read beats at mem_addr 16'h00C0..16'h00C2, mem_we=0, spi_sof on first.
REQ-033 SHALL cover: meta 8'h82, interest_packet=1, entry 11'h40A -> 2 write beats 16'h0280/16'h0281, then 2 read beats same addrs.
REQ-034 SHALL cover: 5 back-to-back events with fib_ready=0, FIFO_DEPTH=4 -> q_full, one drop pulse, drop_cnt=1.
REQ-035 SHALL cover: meta 8'h40 (len 0), entry[10]=1 -> no mem_en, return to IDLE in 1 cycle.
REQ-036 SHALL cover: rst mid-WRITE beat 2 of 8 -> mem_en low next cycle, all outputs 0, queue empty.
